// File: rtl/multicycle_datapath.sv
// Multi-cycle TSC core: IF -> EX -> (MEM) -> IF over one shared memory bus, with HALT as a sink state.
// Requests are registered and held until inputReady/ackOutput; each instruction needs at least one IF wait plus one EX cycle.
module multicycle_datapath #(
  parameter int                   WORD_SIZE   = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC    = '0,
  parameter int                   COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   readM,
  output logic                   writeM,
  output logic [WORD_SIZE-1:0]   address,
  inout  wire  [WORD_SIZE-1:0]   data,
  input  logic                   inputReady,
  input  logic                   ackOutput,
  output logic [COUNT_WIDTH-1:0] num_inst,
  output logic [WORD_SIZE-1:0]   output_port,
  output logic                   output_valid,
  output logic                   is_halted
);
  localparam int W = WORD_SIZE;
  localparam logic [W-1:0]           W_ONE   = W'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  localparam logic [3:0] OP_BNE = 4'd0, OP_BEQ = 4'd1, OP_BGZ = 4'd2, OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4, OP_ORI = 4'd5, OP_LHI = 4'd6, OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8, OP_JMP = 4'd9, OP_RTY = 4'd15;
  localparam logic [5:0] FN_ADD = 6'd0, FN_SUB = 6'd1, FN_AND = 6'd2, FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4, FN_TCP = 6'd5, FN_SHL = 6'd6, FN_SHR = 6'd7;
  localparam logic [5:0] FN_WWD = 6'd28, FN_HLT = 6'd29;

  typedef enum logic [1:0] {S_IF, S_EX, S_MEM, S_HALT} state_t;
  state_t r_state, w_state_nxt;

  logic [15:0]            r_ir;
  logic [W-1:0]           r_pc;
  logic [W-1:0]           r_gpr [4];
  logic                   r_read_m, r_write_m;
  logic [W-1:0]           r_addr, r_wdata, r_out;
  logic                   r_out_vld, r_halted;
  logic [COUNT_WIDTH-1:0] r_num_inst;

  logic [3:0]   w_op;
  logic [1:0]   w_rs_idx, w_rt_idx, w_rd_idx;
  logic [5:0]   w_func;
  logic [7:0]   w_imm;
  logic [11:0]  w_target;
  logic [W-1:0] w_rs, w_rt, w_sext, w_zext, w_lhi, w_pc_inc, w_mem_addr;

  assign w_op       = r_ir[15:12];
  assign w_rs_idx   = r_ir[11:10];
  assign w_rt_idx   = r_ir[9:8];
  assign w_rd_idx   = r_ir[7:6];
  assign w_func     = r_ir[5:0];
  assign w_imm      = r_ir[7:0];
  assign w_target   = r_ir[11:0];
  assign w_rs       = r_gpr[w_rs_idx];
  assign w_rt       = r_gpr[w_rt_idx];
  assign w_sext     = {{(W-8){w_imm[7]}}, w_imm};
  assign w_zext     = W'(w_imm);
  assign w_lhi      = W'({w_imm, 8'h00});
  assign w_pc_inc   = r_pc + W_ONE;
  assign w_mem_addr = w_rs + w_sext;

  logic         w_wr_en, w_is_load, w_is_store, w_is_wwd, w_is_hlt;
  logic [1:0]   w_wr_idx;
  logic [W-1:0] w_wr_dat, w_pc_nxt;
  logic         w_rd_ack, w_wr_ack;

  assign w_rd_ack = r_read_m & inputReady;
  assign w_wr_ack = r_write_m & ackOutput;

  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_idx   = w_rt_idx;
    w_wr_dat   = '0;
    w_pc_nxt   = w_pc_inc;
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_is_wwd   = 1'b0;
    w_is_hlt   = 1'b0;
    case (w_op)
      OP_BNE: if (w_rs != w_rt) w_pc_nxt = w_pc_inc + w_sext;
      OP_BEQ: if (w_rs == w_rt) w_pc_nxt = w_pc_inc + w_sext;
      OP_BGZ: if (!w_rs[W-1] && (w_rs != '0)) w_pc_nxt = w_pc_inc + w_sext;
      OP_BLZ: if (w_rs[W-1]) w_pc_nxt = w_pc_inc + w_sext;
      OP_ADI: begin w_wr_en = 1'b1; w_wr_dat = w_rs + w_sext; end
      OP_ORI: begin w_wr_en = 1'b1; w_wr_dat = w_rs | w_zext; end
      OP_LHI: begin w_wr_en = 1'b1; w_wr_dat = w_lhi; end
      OP_LWD: w_is_load = 1'b1;
      OP_SWD: w_is_store = 1'b1;
      OP_JMP: w_pc_nxt = {r_pc[W-1:12], w_target};
      OP_RTY: begin
        w_wr_idx = w_rd_idx;
        case (w_func)
          FN_ADD: begin w_wr_en = 1'b1; w_wr_dat = w_rs + w_rt; end
          FN_SUB: begin w_wr_en = 1'b1; w_wr_dat = w_rs - w_rt; end
          FN_AND: begin w_wr_en = 1'b1; w_wr_dat = w_rs & w_rt; end
          FN_ORR: begin w_wr_en = 1'b1; w_wr_dat = w_rs | w_rt; end
          FN_NOT: begin w_wr_en = 1'b1; w_wr_dat = ~w_rs; end
          FN_TCP: begin w_wr_en = 1'b1; w_wr_dat = -w_rs; end
          FN_SHL: begin w_wr_en = 1'b1; w_wr_dat = {w_rs[W-2:0], 1'b0}; end
          FN_SHR: begin w_wr_en = 1'b1; w_wr_dat = {w_rs[W-1], w_rs[W-1:1]}; end
          FN_WWD: w_is_wwd = 1'b1;
          FN_HLT: w_is_hlt = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IF:  if (w_rd_ack) w_state_nxt = S_EX;
      S_EX: begin
        if (w_is_load || w_is_store) w_state_nxt = S_MEM;
        else if (w_is_hlt)           w_state_nxt = S_HALT;
        else                         w_state_nxt = S_IF;
      end
      S_MEM: if (w_rd_ack || w_wr_ack) w_state_nxt = S_IF;
      default: w_state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IF;
    else          r_state <= w_state_nxt;
  end

  // IF spends one cycle raising readM before it can accept data, so a response
  // arriving right after reset finds readM low and is dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_read_m   <= 1'b0;
      r_write_m  <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_out      <= '0;
      r_out_vld  <= 1'b0;
      r_halted   <= 1'b0;
      r_num_inst <= '0;
      for (int i = 0; i < 4; i++) r_gpr[i] <= '0;
    end else begin
      r_out_vld <= 1'b0;
      case (r_state)
        S_IF: begin
          if (!r_read_m) begin
            r_read_m <= 1'b1;
            r_addr   <= r_pc;
          end else if (inputReady) begin
            r_ir     <= data[15:0];
            r_read_m <= 1'b0;
          end
        end
        S_EX: begin
          if (w_is_load || w_is_store) begin
            r_addr    <= w_mem_addr;
            r_read_m  <= w_is_load;
            r_write_m <= w_is_store;
            r_wdata   <= w_rt;
          end else begin
            if (w_wr_en) r_gpr[w_wr_idx] <= w_wr_dat;
            if (w_is_wwd) begin
              r_out     <= w_rs;
              r_out_vld <= 1'b1;
            end
            r_num_inst <= r_num_inst + CNT_ONE;
            if (w_is_hlt) r_halted <= 1'b1;
            else          r_pc     <= w_pc_nxt;
          end
        end
        S_MEM: begin
          if (w_rd_ack) begin
            r_gpr[w_rt_idx] <= data;
            r_read_m        <= 1'b0;
            r_pc            <= w_pc_inc;
            r_num_inst      <= r_num_inst + CNT_ONE;
          end else if (w_wr_ack) begin
            r_write_m  <= 1'b0;
            r_pc       <= w_pc_inc;
            r_num_inst <= r_num_inst + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign readM        = r_read_m;
  assign writeM       = r_write_m;
  assign address      = r_addr;
  assign data         = r_write_m ? r_wdata : 'z;
  assign num_inst     = r_num_inst;
  assign output_port  = r_out;
  assign output_valid = r_out_vld;
  assign is_halted    = r_halted;
endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: a delayed-response memory model plus a program table and bus-level corner sequences.
module tb_multicycle_datapath;
  localparam int NV = 21;
  localparam logic [15:0] HLT = 16'hF01D;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        readM, writeM;
  logic [15:0] address;
  wire  [15:0] data;
  logic        inputReady, ackOutput;
  logic [15:0] num_inst, output_port;
  logic        output_valid, is_halted;

  logic        mem_ir, mem_ack, mem_drv, man_ir, man_drv, mem_en;
  logic [15:0] mem_dat, man_dat;
  logic [15:0] mem [0:1023];
  int          lat, wcnt, n_cmp, n_fail, vld_n, wr_cyc;
  logic [15:0] vld_inst, vld_port, wr_addr, wr_dat;
  logic [15:0] rd_log [$];

  assign inputReady = mem_ir | man_ir;
  assign ackOutput  = mem_ack;
  assign data = mem_drv ? mem_dat : (man_drv ? man_dat : 16'hzzzz);

  always #5 clk = ~clk;

  multicycle_datapath dut (
    .clk(clk), .reset_n(reset_n), .readM(readM), .writeM(writeM), .address(address),
    .data(data), .inputReady(inputReady), .ackOutput(ackOutput), .num_inst(num_inst),
    .output_port(output_port), .output_valid(output_valid), .is_halted(is_halted)
  );

  typedef struct {
    string       name;
    logic [15:0] exp_out;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t        vt [NV];
  logic [15:0] vp [NV][8];

  function automatic logic [15:0] it(input int op, input int rs, input int rt, input int imm);
    return {op[3:0], rs[1:0], rt[1:0], imm[7:0]};
  endfunction
  function automatic logic [15:0] rr(input int fn, input int rs, input int rt, input int rd);
    return {4'hF, rs[1:0], rt[1:0], rd[1:0], fn[5:0]};
  endfunction
  function automatic logic [15:0] wwd(input int rs);
    return rr(28, rs, 0, 0);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One cycle: sample outputs at the falling edge, then act as the memory.
  task automatic step();
    @(negedge clk);
    if (output_valid) begin vld_n++; vld_inst = num_inst; vld_port = output_port; end
    if (writeM) begin wr_cyc++; wr_addr = address; wr_dat = data; end
    mem_ir = 1'b0; mem_ack = 1'b0; mem_drv = 1'b0;
    if (mem_en && (readM || writeM)) begin
      wcnt++;
      if (wcnt >= lat) begin
        wcnt = 0;
        if (readM) begin
          mem_ir = 1'b1; mem_drv = 1'b1; mem_dat = mem[address[9:0]];
          rd_log.push_back(address);
        end else begin
          mem_ack = 1'b1; mem[address[9:0]] = data;
        end
      end
    end else wcnt = 0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
  endtask

  task automatic reset_dut();
    reset_n = 1'b0; step(); step(); reset_n = 1'b1;
  endtask

  task automatic run_halt(input string nm, input int bound);
    int g;
    g = 0;
    while (!is_halted && g < bound) begin step(); g++; end
    check({nm, "_halted"}, is_halted, 1);
  endtask

  function automatic logic [15:0] logat(input int idx);
    return (rd_log.size() > idx) ? rd_log[idx] : 16'hDEAD;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n, abad, base, v0, g;
    logic [15:0] ni;
    n_cmp = 0; n_fail = 0; vld_n = 0; wr_cyc = 0; wcnt = 0; lat = 3;
    mem_ir = 0; mem_ack = 0; mem_drv = 0; man_ir = 0; man_drv = 0; mem_en = 0;
    mem_dat = 0; man_dat = 0; reset_n = 1'b0;

    vt[0]  = '{"add", 16'h0008, 16'd5};  vp[0]  = '{it(4,0,1,5), it(4,0,2,3), rr(0,1,2,3), wwd(3), HLT, 0, 0, 0};
    vt[1]  = '{"sub", 16'hFFFE, 16'd5};  vp[1]  = '{it(4,0,1,5), it(4,0,2,7), rr(1,1,2,3), wwd(3), HLT, 0, 0, 0};
    vt[2]  = '{"and", 16'h0030, 16'd5};  vp[2]  = '{it(5,0,1,'hF0), it(4,0,2,'h3C), rr(2,1,2,3), wwd(3), HLT, 0, 0, 0};
    vt[3]  = '{"orr", 16'h00FF, 16'd5};  vp[3]  = '{it(5,0,1,'hF0), it(4,0,2,'h0F), rr(3,1,2,3), wwd(3), HLT, 0, 0, 0};
    vt[4]  = '{"not", 16'hFFF0, 16'd4};  vp[4]  = '{it(4,0,1,'h0F), rr(4,1,0,3), wwd(3), HLT, 0, 0, 0, 0};
    vt[5]  = '{"tcp", 16'hFFFD, 16'd4};  vp[5]  = '{it(4,0,1,3), rr(5,1,0,3), wwd(3), HLT, 0, 0, 0, 0};
    vt[6]  = '{"shl", 16'h0200, 16'd4};  vp[6]  = '{it(6,0,1,'h81), rr(6,1,0,3), wwd(3), HLT, 0, 0, 0, 0};
    vt[7]  = '{"shr", 16'hC080, 16'd4};  vp[7]  = '{it(6,0,1,'h81), rr(7,1,0,3), wwd(3), HLT, 0, 0, 0, 0};
    vt[8]  = '{"adi_sext", 16'hFF80, 16'd3}; vp[8] = '{it(4,0,1,'h80), wwd(1), HLT, 0, 0, 0, 0, 0};
    vt[9]  = '{"ori_zext", 16'h0080, 16'd3}; vp[9] = '{it(5,0,1,'h80), wwd(1), HLT, 0, 0, 0, 0, 0};
    vt[10] = '{"lwd", 16'hBEEF, 16'd4};  vp[10] = '{it(4,0,1,5), it(7,1,2,4), wwd(2), HLT, 0, 0, 0, 0};
    vt[11] = '{"swd_lwd", 16'h1200, 16'd6};
    vp[11] = '{it(4,0,1,5), it(6,0,2,'h12), it(8,1,2,4), it(7,1,3,4), wwd(3), HLT, 0, 0};
    vt[12] = '{"beq_taken", 16'h0000, 16'd5};
    vp[12] = '{it(4,0,1,1), it(4,0,2,1), it(1,1,2,1), it(4,0,3,7), wwd(3), HLT, 0, 0};
    vt[13] = '{"bne_not", 16'h0007, 16'd6};
    vp[13] = '{it(4,0,1,1), it(4,0,2,1), it(0,1,2,1), it(4,0,3,7), wwd(3), HLT, 0, 0};
    vt[14] = '{"bgz_taken", 16'h0000, 16'd4}; vp[14] = '{it(4,0,1,1), it(2,1,0,1), it(4,0,3,7), wwd(3), HLT, 0, 0, 0};
    vt[15] = '{"bgz_zero", 16'h0007, 16'd4};  vp[15] = '{it(2,0,0,1), it(4,0,3,7), wwd(3), HLT, 0, 0, 0, 0};
    vt[16] = '{"blz_taken", 16'h0000, 16'd4}; vp[16] = '{it(4,0,1,'hFF), it(3,1,0,1), it(4,0,3,7), wwd(3), HLT, 0, 0, 0};
    vt[17] = '{"blz_pos", 16'h0007, 16'd5};   vp[17] = '{it(4,0,1,1), it(3,1,0,1), it(4,0,3,7), wwd(3), HLT, 0, 0, 0};
    vt[18] = '{"undef_nop", 16'h0009, 16'd5}; vp[18] = '{it(4,0,1,9), 16'hB1FF, rr(63,0,0,1), wwd(1), HLT, 0, 0, 0};
    vt[19] = '{"jmp", 16'h0000, 16'd3};   vp[19] = '{16'h9004, it(4,0,3,7), HLT, HLT, wwd(3), HLT, 0, 0};
    vt[20] = '{"loop", 16'h0006, 16'd13};
    vp[20] = '{it(4,0,1,3), it(4,0,2,0), it(4,2,2,2), it(4,1,1,'hFF), it(0,1,0,'hFD), wwd(2), HLT, 0};

    // Reset state
    step(); step();
    check("rst_readM", readM, 0);
    check("rst_writeM", writeM, 0);
    check("rst_address", address, 0);
    check("rst_num_inst", num_inst, 0);
    check("rst_output_port", output_port, 0);
    check("rst_output_valid", output_valid, 0);
    check("rst_is_halted", is_halted, 0);

    // 3-cycle fetch latency, ADI then WWD
    clear_mem(); mem[0] = 16'h4101; mem[1] = 16'hF41C; mem[2] = HLT;
    lat = 3; mem_en = 1; reset_n = 1'b1;
    n = 0; abad = 0; g = 0;
    while (!readM && g < 10) begin step(); g++; end
    while (readM && g < 50) begin n++; if (address !== 16'h0000) abad++; step(); g++; end
    check("fetch_readM_cycles", n, 3);
    check("fetch_addr_stable", abad, 0);
    g = 0;
    while (num_inst != 16'd1 && g < 50) begin step(); g++; end
    check("adi_num_inst", num_inst, 1);
    run_halt("adi", 200);
    check("adi_r1_out", output_port, 16'h0001);
    check("adi_final_cnt", num_inst, 3);

    // LHI then WWD: single-cycle valid strobe
    clear_mem(); mem[0] = 16'h6A12; mem[1] = 16'hF81C; mem[2] = HLT;
    reset_dut(); v0 = vld_n;
    run_halt("lhi", 200);
    check("wwd_valid_cycles", vld_n - v0, 1);
    check("wwd_port", vld_port, 16'h1200);
    check("wwd_num_inst", vld_inst, 2);

    // Halt is sticky and quiet
    ni = num_inst; abad = 0;
    for (int i = 0; i < 20; i++) begin step(); if (readM || writeM) abad++; end
    check("halt_no_requests", abad, 0);
    check("halt_num_inst", num_inst, ni);
    check("halt_count", ni, 3);
    check("halt_flag", is_halted, 1);
    reset_n = 1'b0; step(); step();
    check("halt_rst_flag", is_halted, 0);
    check("halt_rst_cnt", num_inst, 0);
    check("halt_rst_port", output_port, 0);
    reset_n = 1'b1;

    // Load and store through rs+sext(imm)
    clear_mem(); mem[0] = it(4,0,1,5); mem[1] = 16'h7604; mem[2] = 16'h8604; mem[3] = HLT;
    mem[9] = 16'hBEEF; lat = 3;
    reset_dut(); base = rd_log.size(); wr_cyc = 0;
    run_halt("ldst", 300);
    check("lwd_addr", logat(base + 2), 16'h0009);
    check("swd_addr", wr_addr, 16'h0009);
    check("swd_data", wr_dat, 16'hBEEF);
    check("swd_held_cycles", wr_cyc, 3);
    check("ldst_cnt", num_inst, 4);

    // Branch/jump fetch addresses
    clear_mem(); mem[0] = it(4,0,1,5); mem[1] = it(4,0,2,5); mem[2] = 16'h900A;
    mem[9] = HLT; mem[10] = 16'h16FE; mem[11] = HLT; lat = 1;
    reset_dut(); base = rd_log.size();
    run_halt("beq", 300);
    check("beq_pc10_fetch", logat(base + 3), 16'h000A);
    check("beq_target", logat(base + 4), 16'h0009);
    check("beq_cnt", num_inst, 5);
    mem[10] = 16'h06FE;
    reset_dut(); base = rd_log.size();
    run_halt("bne", 300);
    check("bne_fallthrough", logat(base + 4), 16'h000B);
    clear_mem(); mem[0] = 16'h9040; mem[16'h40] = 16'h9123; mem[16'h123] = HLT; lat = 2;
    reset_dut(); base = rd_log.size();
    run_halt("jmp", 300);
    check("jmp_to_40", logat(base + 1), 16'h0040);
    check("jmp_to_123", logat(base + 2), 16'h0123);

    // Program table
    for (int k = 0; k < NV; k++) begin
      clear_mem();
      for (int i = 0; i < 8; i++) mem[i] = vp[k][i];
      mem[9] = 16'hBEEF; lat = k % 3 + 1; mem_en = 1;
      reset_dut(); v0 = vld_n;
      run_halt(vt[k].name, 600);
      check({vt[k].name, "_out"}, output_port, vt[k].exp_out);
      check({vt[k].name, "_cnt"}, num_inst, vt[k].exp_cnt);
      check({vt[k].name, "_vld"}, vld_n - v0, 1);
    end

    // Reset during a pending fetch, then a stale inputReady
    clear_mem(); mem[0] = 16'h4101; mem[1] = 16'h4101; mem[2] = 16'h4101; mem[3] = HLT;
    lat = 3; mem_en = 1;
    reset_dut(); g = 0;
    while (!(num_inst == 16'd1 && readM) && g < 100) begin step(); g++; end
    check("abort_pending_addr", address, 16'h0001);
    mem_en = 0; reset_n = 1'b0;
    step();
    check("abort_readM", readM, 0);
    check("abort_cnt", num_inst, 0);
    clear_mem(); mem[0] = 16'hF41C; mem[1] = HLT;
    reset_n = 1'b1; man_ir = 1'b1; man_drv = 1'b1; man_dat = 16'h4101;
    step();
    man_ir = 1'b0; man_drv = 1'b0; mem_en = 1;
    check("abort_refetch_readM", readM, 1);
    check("abort_refetch_pc", address, 16'h0000);
    v0 = vld_n;
    run_halt("abort", 300);
    check("abort_stale_ignored_vld", vld_n - v0, 1);
    check("abort_stale_ignored_port", vld_port, 16'h0000);
    check("abort_final_cnt", num_inst, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised successor to the single-cycle 16-bit datapath: a multi-cycle core with its own control FSM.
- Fetches over a clocked memory handshake, decodes, and executes the TSC R/I/J instruction subset. The subset adds loads/stores, conditional branches and halt.
- Sits between the memory model and the testbench: shares one inout data bus for instruction fetch, load and store.
- Exports a retired-instruction counter and WWD output with a valid strobe.

Parameters:
- WORD_SIZE, 16, datapath/address/bus width; must be >= 16.
- RESET_PC, 0, PC value loaded at reset.
- COUNT_WIDTH, 16, width of num_inst; wraps modulo 2^COUNT_WIDTH.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  reset, synchronous, active-low
- readM  output  1  memory read request (fetch or LWD)
- writeM  output  1  memory write request (SWD)
- address  output  WORD_SIZE  memory address for current request
- data  inout  WORD_SIZE  shared bus; core drives only while writeM=1, else high-Z
- inputReady  input  1  one-cycle pulse: read data valid on data
- ackOutput  input  1  one-cycle pulse: write accepted
- num_inst  output  COUNT_WIDTH  retired instruction count
- output_port  output  WORD_SIZE  last WWD value
- output_valid  output  1  one-cycle pulse when output_port updates
- is_halted  output  1  high once HLT retires

Behaviour:
- Reset: on a clk edge with reset_n=0:
  - pc=RESET_PC; FSM=IF.
  - readM=0, writeM=0, address=0, num_inst=0, output_port=0, output_valid=0, is_halted=0.
  - All 4 registers = 0.
  - Reset asserted mid-handshake aborts the transaction; a late inputReady/ackOutput after reset is ignored.
- Encoding: opcode[15:12], rs[11:10], rt[9:8], rd[7:6], func[5:0], imm[7:0], target[11:0]. Four GPRs. Bits above 15 of a fetched word are ignored.
- FSM states and transitions:
  - IF: readM=1, address=pc. Stay in IF until inputReady=1 is sampled; on that edge latch IR and go to EX. readM drops the next cycle.
  - EX (1 cycle):
    - Compute the ALU result or branch decision.
    - LWD/SWD -> MEM.
    - HLT -> HALT.
    - Everything else: commit (register write, pc update, num_inst+1) on this edge and go to IF.
  - MEM:
    - LWD: readM=1, address=rs+sext(imm); on inputReady, rt<=data, commit, go to IF.
    - SWD: writeM=1, same address, data=rt; on ackOutput, commit, go to IF.
  - HALT: num_inst+1 once on entry, is_halted=1; no further requests until reset.
- Requests are held stable until acknowledged; a response pulse in any other state is ignored.
- pc update:
  - Default: pc+1.
  - JMP: {pc[W-1:12], target}.
  - BNE/BEQ/BGZ/BLZ taken: pc+1+sext(imm).
  - Conditions:
    - BNE/BEQ compare rs vs rt.
    - BGZ: rs signed > 0.
    - BLZ: rs signed < 0.
  - All arithmetic is modulo 2^WORD_SIZE.
- Immediates:
  - ADI/LWD/SWD/branches use sign-extended imm.
  - ORI uses zero-extended imm.
  - LHI loads {imm, 8'b0} into the low 16 bits, with the upper W-16 bits zero.
- ALU (func): ADD 0, SUB 1, AND 2, ORR 3, NOT 4, TCP 5 (two's complement), SHL 6 (logical by 1), SHR 7 (arithmetic by 1). R-type writes rd. ADI/ORI/LHI/LWD write rt.
- WWD (func 28): output_port<=rs; output_valid pulses on the EX edge.
- Undefined opcode/func: treated as NOP; retires and increments num_inst.
- Register read after write: a new value is visible to the next instruction, since there is always at least one IF cycle between them.

Test Plan:
- Reset, then memory answers fetches with a 3-cycle delay: readM held 3 cycles, address=0 throughout; after `0x4101` (ADI $1,$0,1), r1=1 and num_inst=1.
- `0x6A12` (LHI $2,0x12) then `0xF81C` (WWD $2): output_port=0x1200, output_valid high exactly 1 cycle, num_inst=2.
- With r1=0x0005: `0x7604` (LWD $2,4($1)), memory[9]=0xBEEF -> second readM with address=9, r2=0xBEEF. `0x8604` (SWD $2,4($1)) -> writeM=1 with address=9 and data=0xBEEF until ackOutput; data is high-Z otherwise.
- With r1=r2, BEQ `0x16FE` at pc=10 -> next fetch address=9. BNE with the same registers -> address=11. JMP `0x9123` at pc=0x0040 -> address=0x0123.
- `0xF01D` (HLT): is_halted=1, num_inst increments once; readM and writeM stay 0 for 20 cycles; reset clears everything.
- Reset asserted while readM is pending: the next cycle readM=0 and pc=RESET_PC; a stale inputReady one cycle later does not load IR.
